// File: rtl/qsm_acq_channel.sv
// QSM per-channel acquisition engine.
// Reads front-end registers per dimension into a local readout RAM.
module qsm_acq_channel #(
   parameter int unsigned MEM_AW    = 7,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned TIMEOUT_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              ctrl_reset_i,
   input  logic              ctrl_trig_i,
   input  logic [3:0]        last_reg_adr_i,
   input  logic [3:0]        max_dim_no_i,
   input  logic [9:0]        read_delay_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_many_o,
   output logic              err_fb_o,
   output logic [3:0]        dim_count_o,
   output logic              fe_req_o,
   output logic [3:0]        fe_adr_o,
   input  logic [DATA_W-1:0] fe_data_i,
   input  logic              fe_valid_i,
   input  logic              fe_last_i,
   input  logic [MEM_AW-1:0] mem_addr_i,
   output logic [DATA_W-1:0] mem_data_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_REQ,
      S_NEXT,
      S_FINISH
   } state_t;

   localparam logic [TIMEOUT_W-1:0] TO_ONE =
      {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   localparam logic [TIMEOUT_W-1:0] TO_LAST =
      {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   localparam logic [MEM_AW-1:0] PTR_ONE =
      {{(MEM_AW-1){1'b0}}, 1'b1};

   state_t              state_q;
   state_t              state_d;
   logic [9:0]          dly_q;
   logic [TIMEOUT_W-1:0] to_q;
   logic [3:0]          idx_q;
   logic [MEM_AW-1:0]   wr_ptr_q;
   logic                last_q;
   logic                done_q;
   logic                em_q;
   logic                efb_q;
   logic [3:0]          dc_q;
   logic [DATA_W-1:0]   mem_q;
   logic [DATA_W-1:0]   ram_q [0:(1<<MEM_AW)-1];

   logic                to_exp;
   logic                dim_end;
   logic                ram_full;
   logic [3:0]          max_eff;
   logic [3:0]          dc_inc;
   logic                max_hit;
   logic                ram_we;

   assign to_exp   = (to_q == TO_LAST);
   assign dim_end  = (idx_q == last_reg_adr_i);
   assign ram_full = (wr_ptr_q == '0);
   assign max_eff  = (max_dim_no_i == 4'd0) ? 4'd1 : max_dim_no_i;
   assign dc_inc   = (dc_q == 4'hF) ? dc_q : dc_q + 4'd1;
   assign max_hit  = (dc_inc >= max_eff);
   assign ram_we   = (state_q == S_REQ) && fe_valid_i && !ctrl_reset_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state decision; a full RAM after a completed
   // dimension leaves no room for the next one
   always_comb begin
      state_d = state_q;
      if (ctrl_reset_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:   if (ctrl_trig_i) state_d = S_DELAY;
            S_DELAY:  if (dly_q == 10'd0) state_d = S_REQ;
            S_REQ: begin
               if (fe_valid_i)  state_d = S_NEXT;
               else if (to_exp) state_d = S_FINISH;
            end
            S_NEXT: begin
               if (ram_full && !dim_end)          state_d = S_FINISH;
               else if (!dim_end)                 state_d = S_REQ;
               else if (last_q)                   state_d = S_FINISH;
               else if (max_hit || ram_full)      state_d = S_FINISH;
               else                               state_d = S_DELAY;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Moore outputs decoded from the current state
   always_comb begin
      busy_o   = 1'b0;
      fe_req_o = 1'b0;
      unique case (1'b1)
         (state_q == S_REQ): begin
            busy_o   = 1'b1;
            fe_req_o = 1'b1;
         end
         (state_q == S_DELAY),
         (state_q == S_NEXT): busy_o = 1'b1;
         default: ;
      endcase
   end

   // Acquisition datapath and sticky status
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dly_q    <= '0;
         idx_q    <= '0;
         wr_ptr_q <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         em_q     <= 1'b0;
         efb_q    <= 1'b0;
         dc_q     <= '0;
      end else if (ctrl_reset_i) begin
         done_q   <= 1'b0;
         em_q     <= 1'b0;
         efb_q    <= 1'b0;
         dc_q     <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (ctrl_trig_i) begin
                  wr_ptr_q <= '0;
                  idx_q    <= '0;
                  last_q   <= 1'b0;
                  done_q   <= 1'b0;
                  em_q     <= 1'b0;
                  efb_q    <= 1'b0;
                  dc_q     <= '0;
                  dly_q    <= read_delay_i;
               end
            end
            S_DELAY: begin
               if (dly_q != 10'd0) dly_q <= dly_q - 10'd1;
            end
            S_REQ: begin
               if (fe_valid_i) begin
                  wr_ptr_q <= wr_ptr_q + PTR_ONE;
                  last_q   <= fe_last_i;
               end else if (to_exp) begin
                  efb_q  <= 1'b1;
                  done_q <= 1'b1;
               end
            end
            S_NEXT: begin
               if (ram_full && !dim_end) begin
                  em_q   <= 1'b1;
                  done_q <= 1'b1;
               end else if (!dim_end) begin
                  idx_q <= idx_q + 4'd1;
               end else begin
                  dc_q  <= dc_inc;
                  idx_q <= '0;
                  if (last_q) begin
                     done_q <= 1'b1;
                  end else if (max_hit || ram_full) begin
                     em_q   <= 1'b1;
                     done_q <= 1'b1;
                  end else begin
                     dly_q <= read_delay_i;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Response timeout counter, restarted on every request
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         to_q <= '0;
      else if (state_q == S_REQ && !fe_valid_i)
         to_q <= to_q + TO_ONE;
      else
         to_q <= '0;
   end

   // Readout RAM write port (contents are not reset)
   always_ff @(posedge clk_i) begin
      if (ram_we) ram_q[wr_ptr_q] <= fe_data_i;
   end

   // Registered RAM read port; same-address write returns old data
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) mem_q <= '0;
      else          mem_q <= ram_q[mem_addr_i];
   end

   assign done_o      = done_q;
   assign err_many_o  = em_q;
   assign err_fb_o    = efb_q;
   assign dim_count_o = dc_q;
   assign fe_adr_o    = idx_q;
   assign mem_data_o  = mem_q;

endmodule

// File: tb/tb_qsm_acq_channel.sv
// Bench for qsm_acq_channel: cycle-schedule reference model,
// randomized front end and directed corner scenarios.
module tb_qsm_acq_channel;

   localparam int AW    = 7;
   localparam int DW    = 16;
   localparam int TW    = 12;
   localparam int TO    = (1 << TW) - 1;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ctrl_reset = 1'b0;
   logic          ctrl_trig = 1'b0;
   logic [3:0]    last_reg_adr = 4'd0;
   logic [3:0]    max_dim_no = 4'd1;
   logic [9:0]    read_delay = 10'd0;
   logic          busy_o;
   logic          done_o;
   logic          err_many_o;
   logic          err_fb_o;
   logic [3:0]    dim_count_o;
   logic          fe_req_o;
   logic [3:0]    fe_adr_o;
   logic [DW-1:0] fe_data = '0;
   logic          fe_valid = 1'b0;
   logic          fe_last = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_data_o;

   always #5 clk = ~clk;

   qsm_acq_channel #(
      .MEM_AW(AW), .DATA_W(DW), .TIMEOUT_W(TW)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .ctrl_reset_i(ctrl_reset),
      .ctrl_trig_i(ctrl_trig),
      .last_reg_adr_i(last_reg_adr),
      .max_dim_no_i(max_dim_no),
      .read_delay_i(read_delay),
      .busy_o(busy_o),
      .done_o(done_o),
      .err_many_o(err_many_o),
      .err_fb_o(err_fb_o),
      .dim_count_o(dim_count_o),
      .fe_req_o(fe_req_o),
      .fe_adr_o(fe_adr_o),
      .fe_data_i(fe_data),
      .fe_valid_i(fe_valid),
      .fe_last_i(fe_last),
      .mem_addr_i(mem_addr),
      .mem_data_o(mem_data_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // reference model: schedule of absolute cycle numbers
   bit          act = 0;
   int          req_at = -1;
   int          fin_at = -1;
   int          pend_at = -1;
   int          p_dc;
   bit          p_em;
   bit          p_done;
   int          m_dc = 0;
   bit          m_done = 0;
   bit          m_em = 0;
   bit          m_efb = 0;
   int          m_idx = 0;
   int          m_wp = 0;
   bit          m_last = 0;
   logic [DW-1:0] m_ram [DEPTH];
   bit          m_known [DEPTH];

   // stimulus configuration
   int  lat_min = 1;
   int  lat_max = 1;
   int  last_dim = 0;
   int  cur_lat = 1;
   int  resp_n = 0;
   bit  seq_data = 0;
   bit  stray_en = 0;
   bit  no_answer = 0;
   bit  rand_inj = 0;
   int  busy_cnt = 0;
   int  req_cnt = 0;

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, got, exp, cyc);
      end
   endtask

   function automatic bit req_exp();
      return act && req_at >= 0 && cyc >= req_at;
   endfunction

   function automatic bit busy_exp();
      return act && !(fin_at >= 0 && cyc >= fin_at);
   endfunction

   task automatic pend(input int dc, input bit em, input bit dn);
      pend_at = cyc + 1;
      p_dc    = dc;
      p_em    = em;
      p_done  = dn;
   endtask

   task automatic model_clear();
      act = 0; req_at = -1; fin_at = -1; pend_at = -1;
      m_dc = 0; m_done = 0; m_em = 0; m_efb = 0;
   endtask

   task automatic model_start();
      model_clear();
      act = 1;
      m_idx = 0; m_wp = 0; m_last = 0; resp_n = 0;
      req_at = cyc + int'(read_delay) + 1;
   endtask

   // one word arrives; decide what the channel does with it
   task automatic model_accept(input logic [DW-1:0] d, input bit l);
      int nd;
      int mx;
      m_ram[m_wp]   = d;
      m_known[m_wp] = 1;
      m_wp   = (m_wp + 1) % DEPTH;
      m_last = l;
      req_at = -1;
      mx = (max_dim_no == 0) ? 1 : int'(max_dim_no);
      if (m_wp == 0 && m_idx != int'(last_reg_adr)) begin
         pend(m_dc, 1, 1);
         fin_at = cyc + 1;
      end else if (m_idx != int'(last_reg_adr)) begin
         m_idx++;
         req_at = cyc + 1;
      end else begin
         nd = (m_dc < 15) ? m_dc + 1 : 15;
         m_idx = 0;
         if (m_last) begin
            pend(nd, 0, 1);
            fin_at = cyc + 1;
         end else if (nd >= mx || m_wp == 0) begin
            pend(nd, 1, 1);
            fin_at = cyc + 1;
         end else begin
            pend(nd, 0, 0);
            req_at = cyc + int'(read_delay) + 2;
         end
      end
   endtask

   // advance one clock, update model, compare every output
   task automatic step();
      bit p_rst, p_trig, p_val, p_lst, p_req, mk;
      logic [DW-1:0] p_dat, me;
      logic [AW-1:0] p_addr;
      p_rst  = ctrl_reset;
      p_trig = ctrl_trig;
      p_val  = fe_valid;
      p_lst  = fe_last;
      p_dat  = fe_data;
      p_addr = mem_addr;
      p_req  = req_exp();
      @(posedge clk);
      #1;
      cyc++;
      ctrl_reset = 0;
      ctrl_trig  = 0;
      fe_valid   = 0;
      fe_last    = 0;
      mk = m_known[p_addr];
      me = m_ram[p_addr];
      if (p_rst)                model_clear();
      else if (p_trig && !act)  model_start();
      else if (p_val && p_req)  model_accept(p_dat, p_lst);
      if (act && fin_at >= 0 && cyc == fin_at + 1) act = 0;
      if (pend_at == cyc) begin
         m_dc   = p_dc;
         m_em   = m_em | p_em;
         m_done = m_done | p_done;
         pend_at = -1;
      end
      if (req_exp() && cyc == req_at + TO) begin
         m_efb = 1; m_done = 1; fin_at = cyc; req_at = -1;
      end
      if (busy_o === 1'b1)   busy_cnt++;
      if (fe_req_o === 1'b1) req_cnt++;
      check("busy", busy_o, busy_exp());
      check("fe_req", fe_req_o, req_exp());
      if (req_exp()) check("fe_adr", fe_adr_o, m_idx);
      check("done", done_o, m_done);
      check("err_many", err_many_o, m_em);
      check("err_fb", err_fb_o, m_efb);
      check("dim_count", dim_count_o, m_dc);
      if (mk) check("mem_data", mem_data_o, me);
   endtask

   // front-end responder and random read address
   task automatic drive();
      int age;
      if (req_exp()) begin
         age = cyc - req_at;
         if (age == 0) cur_lat = $urandom_range(lat_max, lat_min);
         if (!no_answer && age + 1 >= cur_lat) begin
            fe_valid = 1;
            fe_data  = seq_data ? DW'(16'hA000 + resp_n)
                                : DW'($urandom);
            fe_last  = (last_dim > 0) &&
               ((resp_n / (int'(last_reg_adr) + 1)) + 1 == last_dim);
            resp_n++;
         end
      end else if (stray_en && $urandom_range(9, 0) == 0) begin
         fe_valid = 1;
         fe_data  = DW'($urandom);
         fe_last  = 1'($urandom);
      end
      if ($urandom_range(3, 0) == 0) mem_addr = m_wp[AW-1:0];
      else mem_addr = AW'($urandom_range(DEPTH - 1, 0));
   endtask

   task automatic cycle();
      drive();
      step();
   endtask

   task automatic set_cfg(input int l, input int md, input int d,
                          input int lmin, input int lmax,
                          input int ld);
      last_reg_adr = 4'(l);
      max_dim_no   = 4'(md);
      read_delay   = 10'(d);
      lat_min  = lmin;
      lat_max  = lmax;
      last_dim = ld;
   endtask

   task automatic start_acq();
      busy_cnt = 0;
      req_cnt  = 0;
      ctrl_trig = 1;
      cycle();
   endtask

   task automatic finish_acq(input int budget);
      int n = 0;
      while (act && n < budget) begin
         if (rand_inj) begin
            if ($urandom_range(199, 0) == 0) ctrl_reset = 1;
            if ($urandom_range(39, 0) == 0)  ctrl_trig = 1;
         end
         cycle();
         n++;
      end
      n_tests++;
      if (act) begin
         n_fail++;
         $display("FAIL acq_budget: busy after %0d cycles, need idle",
                  n);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         m_known[i] = 0;
         m_ram[i]   = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err_many", err_many_o, 0);
      check("rst_err_fb", err_fb_o, 0);
      check("rst_dim_count", dim_count_o, 0);
      check("rst_fe_req", fe_req_o, 0);
      check("rst_fe_adr", fe_adr_o, 0);
      check("rst_mem_data", mem_data_o, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (2) step();

      // basic run: 2 dims of 4 regs, fe_last on dim 2
      seq_data = 1;
      set_cfg(3, 2, 5, 2, 2, 2);
      start_acq();
      finish_acq(200);
      check("s1_dim_count", dim_count_o, 2);
      check("s1_done", done_o, 1);
      check("s1_err_many", err_many_o, 0);
      check("s1_err_fb", err_fb_o, 0);
      check("s1_busy_cycles", busy_cnt, 36);
      check("s1_req_cycles", req_cnt, 16);
      seq_data = 0;
      for (int i = 0; i < 8; i++) begin
         mem_addr = AW'(i);
         step();
         check("s1_ram", mem_data_o, 16'hA000 + i);
         mem_addr = AW'((i + 1) % 8);
         check("s1_latency", mem_data_o, 16'hA000 + i);
      end

      // front end never answers
      no_answer = 1;
      set_cfg(0, 1, 0, 1, 1, 0);
      start_acq();
      finish_acq(5000);
      check("s2_req_cycles", req_cnt, 4095);
      check("s2_err_fb", err_fb_o, 1);
      check("s2_done", done_o, 1);
      check("s2_busy", busy_o, 0);
      check("s2_dim_count", dim_count_o, 0);
      no_answer = 0;

      // max_dim=1, no fe_last
      set_cfg(1, 1, 2, 1, 3, 0);
      start_acq();
      finish_acq(200);
      check("s3_err_many", err_many_o, 1);
      check("s3_dim_count", dim_count_o, 1);

      // RAM fill: 16 regs x 8 dims
      set_cfg(15, 15, 0, 1, 1, 0);
      start_acq();
      finish_acq(1000);
      check("s4_err_many", err_many_o, 1);
      check("s4_dim_count", dim_count_o, 8);
      check("s4_done", done_o, 1);

      // abort mid-request with a colliding write
      set_cfg(1, 4, 2, 3, 3, 0);
      start_acq();
      for (int n = 0; n < 200 && !(req_exp() && resp_n >= 3); n++)
         cycle();
      check("s5_dim_before", dim_count_o, 1);
      check("s5_req_before", fe_req_o, 1);
      ctrl_reset = 1;
      fe_valid   = 1;
      fe_data    = 16'hDEAD;
      step();
      check("s5_fe_req", fe_req_o, 0);
      check("s5_busy", busy_o, 0);
      check("s5_dim_count", dim_count_o, 0);
      check("s5_done", done_o, 0);
      mem_addr = 7'd3;
      step();
      check("s5_no_write", mem_data_o == 16'hDEAD, 0);
      set_cfg(0, 1, 1, 1, 2, 1);
      start_acq();
      finish_acq(200);
      check("s5_restart_done", done_o, 1);
      check("s5_restart_dim", dim_count_o, 1);
      check("s5_restart_err", err_many_o, 0);

      // reset and trig together, then trig while busy
      ctrl_reset = 1;
      ctrl_trig  = 1;
      step();
      check("s6_rst_trig_busy", busy_o, 0);
      step();
      check("s6_rst_trig_busy2", busy_o, 0);
      set_cfg(0, 2, 3, 1, 1, 2);
      start_acq();
      repeat (3) cycle();
      ctrl_trig = 1;
      finish_acq(200);
      check("s6_busy_cycles", busy_cnt, 12);
      check("s6_dim_count", dim_count_o, 2);
      check("s6_done", done_o, 1);

      // randomized runs
      stray_en = 1;
      rand_inj = 1;
      for (int r = 0; r < 40; r++) begin
         set_cfg($urandom_range(3, 0), $urandom_range(5, 0),
                 $urandom_range(6, 0), 1, $urandom_range(4, 1),
                 $urandom_range(4, 0));
         repeat ($urandom_range(3, 0)) cycle();
         start_acq();
         finish_acq(3000);
         repeat (2) cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
